fib_pair_serializer: RTL and testbench
======================================

Name: fib_pair_serializer

Overview:
- Downstream consumer of the two-per-cycle Fibonacci generator. Accepts one pair of terms per transfer (num, num2) and emits them as a single-word stream, first term then second term.
- Holds pairs in a small FIFO so the producer and consumer can run at different rates.
- Tracks the number of emitted words, and sets a sticky flag once the 16-bit sequence wraps.
- Sits between the pair generator and single-rate consumers such as checkers and display logic.

Parameters:
- W, 16: word width of each Fibonacci term.
- DEPTH, 4: FIFO capacity in pairs. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted; assertion takes effect immediately, deassertion is sampled at posedge).
- in_valid  input  1  a pair is presented on in_num/in_num2.
- in_ready  output  1  FIFO can accept a pair.
- in_num  input  W  first (earlier) term of the pair.
- in_num2  input  W  second (later) term of the pair.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  current serialized word.
- out_count  output  16  number of words accepted downstream, modulo 2^16.
- wrap_seen  output  1  sticky flag: an emitted word was smaller than the previous emitted word.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr, wr_ptr and the occupancy counter clear to 0; half clears to 0.
  - out_count clears to 0, wrap_seen to 0, last_word to 0.
  - Outputs immediately: in_ready=1, out_valid=0, out_data=0.
  - FIFO storage is not reset.
- Input handshake:
  - push = in_valid && in_ready. The pair {in_num, in_num2} is written at that posedge.
  - in_ready = !full, driven from registered state only. There is no combinational path from out_ready to in_ready.
  - When the FIFO is full, a pop in the same cycle does not allow a push; in_ready stays 0 that cycle.
- Output handshake:
  - out_valid = !empty.
  - out_data is num of the head pair when half=0 and num2 of the head pair when half=1. out_data is 0 whenever out_valid=0.
  - xfer = out_valid && out_ready. On xfer, half toggles.
  - On xfer with half=1, the head pair is popped (rd_ptr increments and wraps at DEPTH).
  - While out_ready=0, out_data and out_valid stay stable.
- Latency: a pair pushed at posedge t gives out_valid=1 with its first term after t, i.e. it is visible in cycle t+1. There is no bypass into an empty FIFO.
- Throughput: one word per cycle downstream, so at most one pair every 2 cycles is sustained. An upstream producer that emits a pair every cycle must honour in_ready.
- Simultaneous push and pop: allowed whenever not full. Occupancy is unchanged.
- Pointers: log2(DEPTH)+1 bits; full/empty are derived from the MSB comparison.
- out_count: increments by 1 on every xfer and wraps 65535 -> 0 silently.
- wrap_seen: on xfer, if out_data < last_word (unsigned), wrap_seen is set to 1 and stays set until reset. last_word is then loaded with out_data. The first word can never set the flag.
- Reset mid-operation: all buffered pairs are discarded and the partial pair state (half) is lost. After deassertion the block behaves as freshly reset.

Decomposition:
- Package fib_pkg:
  - W_DEFAULT = 16.
  - typedef word_t = logic [W-1:0].
  - typedef pair_t = packed struct {word_t first; word_t second;}.
- Sub-module fib_pair_fifo: a generic synchronous FIFO of pair_t with DEPTH, push/pop and full/empty, with the same clk/rst convention.
- The serializer top holds half, out_count, last_word and wrap_seen.

Test Plan:
- Reset check: hold rst=0, then release. Expect in_ready=1, out_valid=0, out_data=0, out_count=0, wrap_seen=0. Assert rst=0 between clock edges and expect the outputs to clear before the next posedge.
- Streaming: push pairs (1,1), (2,3), (5,8) with out_ready=1. Expect out_data 1,1,2,3,5,8 on consecutive accepted cycles, out_count=6, wrap_seen=0.
- Backpressure fill: out_ready=0, push 4 pairs. Expect in_ready=0 after the 4th push, and a 5th pair held by in_valid is not accepted. Then raise out_ready and expect all 8 words in order.
- Mid-pair stall: with out_data=2 (half=0 of (2,3)), drop out_ready for 3 cycles. Expect out_data to stay 2 and out_count to stay constant. Resume and expect 3 next.
- Wrap detection: push (28657,46368) then (9489,55857). Expect wrap_seen to go to 1 on the cycle 9489 is accepted and to stay 1 afterwards.
- Async reset mid-operation: with 3 pairs buffered and half=1, pulse rst=0. Expect out_valid=0 and out_count=0 immediately. After release, push (1,1) and expect out_data=1 with half=0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair path: word and pair layouts used by the
// serializer and its pair FIFO.
package fib_pkg;
  localparam int W_DEFAULT = 16;
  localparam int W = W_DEFAULT;

  typedef logic [W-1:0] word_t;

  typedef struct packed {
    word_t first;
    word_t second;
  } pair_t;
endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous FIFO of pairs with extra-MSB pointers; storage is not reset,
// only the pointers are.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter type T     = pair_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     wr_data_i,
  input  logic pop_i,
  output T     rd_data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  T            mem_q [DEPTH];

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + PTR_ONE;
    if (pop_i && !empty_o) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/fib_pair_serializer.sv
// Buffers (num, num2) pairs and emits them as a single-word stream, first
// term then second, with a word counter and a sticky sequence-wrap flag.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [15:0]  out_count,
  output logic         wrap_seen
);
  typedef struct packed {
    logic [W-1:0] first;
    logic [W-1:0] second;
  } ser_pair_t;

  ser_pair_t    wr_pair, head;
  logic         full, empty, push, pop, xfer;
  logic         half_q, half_d;
  logic [15:0]  out_count_q, out_count_d;
  logic [W-1:0] last_word_q, last_word_d;
  logic         wrap_q, wrap_d;

  // Handshake: a transfer happens on a posedge where valid && ready. in_ready
  // depends only on registered FIFO state, and out_valid/out_data hold steady
  // while out_ready is low.
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign pop = xfer && half_q;
  assign wr_pair = '{first: in_num, second: in_num2};

  fib_pair_fifo #(
    .T     (ser_pair_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (wr_pair),
    .pop_i     (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = half_q ? head.second : head.first;
  end

  always_comb begin
    half_d      = half_q;
    out_count_d = out_count_q;
    last_word_d = last_word_q;
    wrap_d      = wrap_q;
    if (xfer) begin
      half_d      = !half_q;
      out_count_d = out_count_q + 16'd1;
      last_word_d = out_data;
      // last_word starts at 0, so the first word can never trip the flag.
      if (out_data < last_word_q) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_q      <= 1'b0;
      out_count_q <= '0;
      last_word_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      half_q      <= half_d;
      out_count_q <= out_count_d;
      last_word_q <= last_word_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out_count = out_count_q;
  assign wrap_seen = wrap_q;
endmodule

// File: tb/tb_fib_pair_serializer.sv
// Randomized and directed bench for fib_pair_serializer against a word-queue
// reference model.
module tb_fib_pair_serializer;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_num = '0;
  logic [W-1:0] in_num2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [15:0]  out_count;
  logic         wrap_seen;

  fib_pair_serializer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_num2   (in_num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .wrap_seen (wrap_seen)
  );

  always #5 clk = ~clk;

  // Reference model: the words still owed downstream, in emission order.
  logic [W-1:0] exp_q[$];
  int           m_count;
  logic         m_wrap;
  logic [W-1:0] m_last;
  int           vectors;
  int           miscompares;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count = 0;
    m_wrap  = 1'b0;
    m_last  = '0;
  endtask

  task automatic check_outputs();
    int   pairs;
    logic e_vld;
    pairs = (exp_q.size() + 1) / 2;
    e_vld = exp_q.size() > 0;
    check_eq("in_ready", in_ready, pairs < DEPTH);
    check_eq("out_valid", out_valid, e_vld);
    check_eq("out_data", out_data, e_vld ? exp_q[0] : '0);
    check_eq("out_count", out_count, m_count);
    check_eq("wrap_seen", wrap_seen, m_wrap);
  endtask

  // One clock: check at the negedge, then drive and advance the model for the
  // coming posedge.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy);
    int           pairs;
    logic         e_rdy, e_vld;
    logic [W-1:0] word;
    @(negedge clk);
    check_outputs();
    pairs = (exp_q.size() + 1) / 2;
    e_rdy = pairs < DEPTH;
    e_vld = exp_q.size() > 0;
    in_valid  = iv;
    in_num    = a;
    in_num2   = b;
    out_ready = ordy;
    if (e_vld && ordy) begin
      word = exp_q.pop_front();
      if (word < m_last) m_wrap = 1'b1;
      m_last  = word;
      m_count = (m_count + 1) % 65536;
    end
    if (iv && e_rdy) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_clear();

    #7;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Streaming three pairs back to back.
    step(1'b1, 16'd1, 16'd1, 1'b1);
    step(1'b1, 16'd2, 16'd3, 1'b1);
    step(1'b1, 16'd5, 16'd8, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 1'b1);
    check_eq("stream_count", out_count, 16'd6);

    // Backpressure: fill, hold a fifth pair, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 16'(10 + 2 * i), 16'(11 + 2 * i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd99, 16'd98, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1);

    // Mid-pair stall on a pair's first term, then on its second.
    step(1'b1, 16'd2, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1);

    // Reset with three pairs buffered and the head half-consumed.
    for (int i = 0; i < 3; i++) step(1'b1, 16'(40 + i), 16'(50 + i), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    async_reset();
    step(1'b1, 16'd1, 16'd1, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check_eq("post_reset_data", out_data, 16'd1);

    // Sequence wrap: 9489 follows 46368.
    step(1'b1, 16'd28657, 16'd46368, 1'b1);
    step(1'b1, 16'd9489, 16'd55857, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);
    check_eq("wrap_sticky", wrap_seen, 1'b1);

    async_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
